// File: rtl/led_blink_pkg.sv
// led_blink_pkg: shared constants for the LED blink generator.
//   LED_ON / LED_OFF : active and inactive LED drive levels
//   CLK_HZ           : default board clock frequency (27 MHz)
//   ms_to_half_period: converts a half-period in milliseconds to a
//                      terminal count (cycles - 1) at a given clock rate
package led_blink_pkg;

    localparam logic        LED_ON  = 1'b1;
    localparam logic        LED_OFF = ~LED_ON;
    localparam int unsigned CLK_HZ  = 27_000_000;

    // A half-period of ms milliseconds lasts (clk_hz/1000)*ms cycles; the
    // counter wraps at that count minus one.
    function automatic int unsigned ms_to_half_period(input int unsigned ms,
                                                      input int unsigned clk_hz);
        return ((clk_hz / 32'd1000) * ms) - 32'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes the raw active-low push-button into the clk
// domain and (optionally) debounces it.
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   key_n  in  raw push-button, active-low, asynchronous to clk
//   fast_o out debounced key state, 1 = pressed
// Build option: KEY_DEBOUNCE_EN compiles in the DB_CYC stability filter;
// without it fast_o is the inverted synchronizer output (2-cycle latency).
module key_debounce #(
    parameter int unsigned DB_CYC = 270_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic fast_o
);

    logic [1:0] sync_q;
    logic       pressed_s;

    // Two-flop synchronizer; resets to the released (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n};
        end
    end

    assign pressed_s = ~sync_q[1];

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned     DB_W    = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            fast_q;
    logic            fast_d;

    // Count consecutive cycles where the synchronized key disagrees with the
    // accepted state; a single agreeing cycle (bounce) restarts the window.
    always_comb begin
        db_cnt_d = '0;
        fast_d   = fast_q;
        if (pressed_s != fast_q) begin
            if (db_cnt_q == DB_LAST) begin
                fast_d   = pressed_s;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_d = '0;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q <= '0;
            fast_q   <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            fast_q   <= fast_d;
        end
    end

    assign fast_o = fast_q;
`else
    assign fast_o = pressed_s;
`endif

endmodule

// File: rtl/led_blink_gen.sv
// led_blink_gen: CH independent LED blinkers with run-time programmable
// slow/fast half-period limits and a debounced fast-mode key.
//   clk, rst        clock, asynchronous active-high reset
//   key_n           raw active-low fast-mode button
//   ch_en[CH]       per-channel enable level
//   resync          pulse: restart all enabled channels with LED on
//   cfg_we/cfg_ch/cfg_sel/cfg_data  single-cycle limit write port
//                   (cfg_sel 0 = slow limit, 1 = fast limit)
//   led[CH]         registered LED drive
//   wrap[CH]        registered one-cycle pulse on every LED toggle
//   fast_o          registered debounced key state
// Build option: KEY_DEBOUNCE_EN enables the key debouncer (see key_debounce).
module led_blink_gen
    import led_blink_pkg::*;
#(
    parameter  int unsigned CH          = 4,
    parameter  int unsigned CNT_W       = 32,
    parameter  int unsigned PERIOD_SLOW = ms_to_half_period(32'd500, CLK_HZ),
    parameter  int unsigned PERIOD_FAST = ms_to_half_period(32'd100, CLK_HZ),
    parameter  int unsigned DB_CYC      = 270_000,
    localparam int unsigned CW          = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_n,
    input  logic [CH-1:0]    ch_en,
    input  logic             resync,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_ch,
    input  logic             cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
    output logic [CH-1:0]    led,
    output logic [CH-1:0]    wrap,
    output logic             fast_o
);

    logic fast_s;

    key_debounce #(
        .DB_CYC (DB_CYC)
    ) u_key_debounce (
        .clk    (clk),
        .rst    (rst),
        .key_n  (key_n),
        .fast_o (fast_s)
    );

    assign fast_o = fast_s;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [CNT_W-1:0] slow_lim_q, slow_lim_d;
        logic [CNT_W-1:0] fast_lim_q, fast_lim_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] lim_s;
        logic             led_q, led_d;
        logic             wrap_q, wrap_d;
        logic             hit_s;

        // Channel indices >= CH never match, so such writes fall through.
        assign hit_s = cfg_we && (cfg_ch == CW'(i));

        // Limit write decode: the new value is compared from the next cycle.
        always_comb begin
            slow_lim_d = slow_lim_q;
            fast_lim_d = fast_lim_q;
            if (hit_s) begin
                if (cfg_sel) begin
                    fast_lim_d = cfg_data;
                end else begin
                    slow_lim_d = cfg_data;
                end
            end else begin
                slow_lim_d = slow_lim_q;
            end
        end

        // Counter / LED next state. The >= compare makes a lowered limit or
        // a switch to a shorter mode wrap at once instead of rolling over.
        always_comb begin
            lim_s  = fast_s ? fast_lim_q : slow_lim_q;
            cnt_d  = cnt_q;
            led_d  = led_q;
            wrap_d = 1'b0;
            if (!ch_en[i]) begin
                cnt_d = '0;
                led_d = LED_OFF;
            end else if (resync) begin
                cnt_d = '0;
                led_d = LED_ON;
            end else if (cnt_q >= lim_s) begin
                cnt_d  = '0;
                led_d  = ~led_q;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Channel state registers; reset restores the parameter limits.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slow_lim_q <= CNT_W'(PERIOD_SLOW);
                fast_lim_q <= CNT_W'(PERIOD_FAST);
                cnt_q      <= '0;
                led_q      <= LED_OFF;
                wrap_q     <= 1'b0;
            end else begin
                slow_lim_q <= slow_lim_d;
                fast_lim_q <= fast_lim_d;
                cnt_q      <= cnt_d;
                led_q      <= led_d;
                wrap_q     <= wrap_d;
            end
        end

        assign led[i]  = led_q;
        assign wrap[i] = wrap_q;
    end

endmodule

// File: tb/tb_led_blink_gen.sv
// Directed self-checking bench for led_blink_gen (CH=3, slow=9, fast=3,
// DB_CYC=4). Expected key latency depends on whether KEY_DEBOUNCE_EN is set.
module tb_led_blink_gen;

    localparam int CH    = 3;
    localparam int CNT_W = 32;

`ifdef KEY_DEBOUNCE_EN
    localparam int   KEY_LAT    = 6;
    localparam logic PULSE_SEEN = 1'b0;
`else
    localparam int   KEY_LAT    = 2;
    localparam logic PULSE_SEEN = 1'b1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             key_n;
    logic [CH-1:0]    ch_en;
    logic             resync;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic             cfg_sel;
    logic [CNT_W-1:0] cfg_data;
    logic [CH-1:0]    led;
    logic [CH-1:0]    wrap;
    logic             fast_o;

    int n_assert = 0;
    int n_fail   = 0;

    led_blink_gen #(
        .CH          (CH),
        .CNT_W       (CNT_W),
        .PERIOD_SLOW (9),
        .PERIOD_FAST (3),
        .DB_CYC      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_n    (key_n),
        .ch_en    (ch_en),
        .resync   (resync),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .led      (led),
        .wrap     (wrap),
        .fast_o   (fast_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; key_n = 1'b1; ch_en = 3'b000; resync = 1'b0;
        cfg_we = 1'b0; cfg_ch = 2'd0; cfg_sel = 1'b0; cfg_data = 32'd0;

        // Reset state
        tick(3);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_fast", 32'(fast_o), 32'd0);

        // Basic blink: enable ch0/ch1, first rise 10 cycles later
        rst = 1'b0; ch_en = 3'b011;
        tick(9);
        chk("blink_pre_led", 32'(led), 32'd0);
        chk("blink_pre_wrap", 32'(wrap), 32'd0);
        tick(1);
        chk("blink_rise_led", 32'(led), 32'h3);
        chk("blink_rise_wrap", 32'(wrap), 32'h3);
        tick(1);
        chk("blink_hold_led", 32'(led), 32'h3);
        chk("blink_wrap_1cyc", 32'(wrap), 32'd0);
        tick(8);
        chk("blink_hold2_led", 32'(led), 32'h3);
        tick(1);
        chk("blink_fall_led", 32'(led), 32'd0);
        chk("blink_fall_wrap", 32'(wrap), 32'h3);

        // Short 3-cycle key bounce
        key_n = 1'b0;
        tick(2);
        chk("bounce_p2", 32'(fast_o), 32'(PULSE_SEEN));
        tick(1);
        key_n = 1'b1;
        tick(1);
        chk("bounce_p4", 32'(fast_o), 32'(PULSE_SEEN));
        tick(2);
        chk("bounce_p6", 32'(fast_o), 32'd0);
        tick(2);

        // Long press
        key_n = 1'b0;
        tick(KEY_LAT - 1);
        chk("press_pre", 32'(fast_o), 32'd0);
        tick(1);
        chk("press_edge", 32'(fast_o), 32'd1);

        // Fast mode half-period of 4, aligned by resync
        resync = 1'b1;
        tick(1);
        resync = 1'b0;
        chk("fast_rs_led", 32'(led), 32'h3);
        chk("fast_rs_wrap", 32'(wrap), 32'd0);
        tick(3);
        chk("fast_hold_led", 32'(led), 32'h3);
        tick(1);
        chk("fast_fall_led", 32'(led), 32'd0);
        chk("fast_fall_wrap", 32'(wrap), 32'h3);
        tick(3);
        chk("fast_low_led", 32'(led), 32'd0);
        tick(1);
        chk("fast_rise_led", 32'(led), 32'h3);
        chk("fast_rise_wrap", 32'(wrap), 32'h3);

        // Release key
        key_n = 1'b1;
        tick(KEY_LAT - 1);
        chk("release_pre", 32'(fast_o), 32'd1);
        tick(1);
        chk("release_edge", 32'(fast_o), 32'd0);

        // Knock ch1 out of phase, then resync
        ch_en = 3'b001;
        tick(1);
        chk("disable_led1", 32'(led[1]), 32'd0);
        chk("disable_wrap1", 32'(wrap[1]), 32'd0);
        ch_en = 3'b011;
        tick(3);
        resync = 1'b1;
        tick(1);
        resync = 1'b0;
        chk("resync_led", 32'(led), 32'h3);
        chk("resync_wrap", 32'(wrap), 32'd0);
        tick(9);
        chk("resync_hold_led", 32'(led), 32'h3);
        tick(1);
        chk("resync_fall_led", 32'(led), 32'd0);
        chk("resync_fall_wrap", 32'(wrap), 32'h3);

        // Lower ch0 slow limit to 5 while its count is 7
        tick(7);
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = 1'b0; cfg_data = 32'd5;
        tick(1);
        cfg_we = 1'b0;
        chk("lower_wr_led", 32'(led), 32'd0);
        tick(1);
        chk("lower_wrap_led", 32'(led), 32'h1);
        chk("lower_wrap_wrap", 32'(wrap), 32'h1);
        tick(1);
        chk("lower_ch1_led", 32'(led), 32'h3);
        chk("lower_ch1_wrap", 32'(wrap), 32'h2);
        tick(4);
        chk("lower_hold_led", 32'(led), 32'h3);
        tick(1);
        chk("lower_6cyc_led", 32'(led), 32'h2);
        chk("lower_6cyc_wrap", 32'(wrap), 32'h1);

        // Write to channel 3 (out of range) must change nothing
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_sel = 1'b0; cfg_data = 32'd1;
        tick(1);
        cfg_we = 1'b0;
        tick(3);
        chk("oob_hold_led", 32'(led), 32'h2);
        chk("oob_hold_wrap", 32'(wrap), 32'd0);
        tick(1);
        chk("oob_ch1_led", 32'(led), 32'd0);
        chk("oob_ch1_wrap", 32'(wrap), 32'h2);
        tick(1);
        chk("oob_ch0_led", 32'(led), 32'h1);
        chk("oob_ch0_wrap", 32'(wrap), 32'h1);

        // Asynchronous reset mid-count
        #2;
        rst = 1'b1;
        #1;
        chk("arst_led", 32'(led), 32'd0);
        chk("arst_wrap", 32'(wrap), 32'd0);
        chk("arst_fast", 32'(fast_o), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(9);
        chk("post_rst_pre_led", 32'(led), 32'd0);
        tick(1);
        chk("post_rst_rise_led", 32'(led), 32'h3);
        chk("post_rst_rise_wrap", 32'(wrap), 32'h3);
        tick(9);
        chk("post_rst_hold_led", 32'(led), 32'h3);
        tick(1);
        chk("post_rst_fall_led", 32'(led), 32'd0);
        chk("post_rst_fall_wrap", 32'(wrap), 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/led_blink_gen.md
# led_blink_gen

Multi-channel LED blink generator for the FPGA board top level. It drives CH independent LED outputs, each with a run-time programmable slow and fast half-period. A debounced key selects fast mode for all channels. Limits are written from the Cortex-M3 GPIO/AHB side through a single-cycle write port, and per-channel wrap pulses are suitable for an MCU user interrupt.

## Interface
- CH, 4: number of LED channels (1..16).
- CNT_W, 32: counter and limit width.
- PERIOD_SLOW, 13_499_999: reset value of every slow half-period limit (500 ms at 27 MHz, minus 1).
- PERIOD_FAST, 2_699_999: reset value of every fast half-period limit (100 ms, minus 1).
- DB_CYC, 270_000: debounce stability window in clk cycles (10 ms).
- LED_ON, 1'b1: active LED level; LED_OFF = !LED_ON.

Ports:
- clk  in  1  system clock (27 MHz board clock).
- rst  in  1  reset. Asynchronous assertion, active-high; clears all state.
- key_n  in  1  raw push-button, active-low, asynchronous to clk.
- ch_en  in  CH  per-channel enable, level.
- resync  in  1  one-cycle pulse that phase-aligns all channels.
- cfg_we  in  1  limit write strobe, one cycle.
- cfg_ch  in  CW  target channel, with CW = max(1, $clog2(CH)).
- cfg_sel  in  1  0 selects the slow limit, 1 selects the fast limit.
- cfg_data  in  CNT_W  new limit value.
- led  out  CH  LED drive, registered.
- wrap  out  CH  one-cycle pulse on each LED toggle, registered.
- fast_o  out  1  debounced key state (1 = pressed = fast mode), registered.

## Operation
- Key path: key_n passes through a 2-FF synchronizer and then the debouncer (see Configuration). The result is the internal level `fast`, which also drives fast_o.
- Limit registers: slow_lim[i] and fast_lim[i], each CNT_W wide.
  - On cfg_we, the register selected by cfg_ch and cfg_sel loads cfg_data.
  - A write with cfg_ch >= CH is ignored.
  - A value of 0 is legal and means the LED toggles every cycle.
- Active limit: lim[i] = fast ? fast_lim[i] : slow_lim[i].
- Per-channel counter cnt[i], CNT_W bits, evaluated in this priority order:
  - ch_en[i]=0: cnt=0, led[i]=LED_OFF, wrap[i]=0.
  - resync=1: cnt=0, led[i]=LED_ON, wrap[i]=0. This applies to enabled channels only.
  - cnt >= lim[i]: cnt=0, led[i] toggles, wrap[i]=1.
  - otherwise: cnt increments and wrap[i]=0.
- The `>=` compare is required. A limit lowered below the current count, or a mode switch to a shorter limit, wraps on the next cycle and never runs through the full 2^CNT_W count.
- cfg_we and resync in the same cycle: both take effect. The new limit is compared from the following cycle onward.
- Reset values:
  - led = all LED_OFF, wrap = 0, fast_o = 0, cnt = 0.
  - slow_lim = PERIOD_SLOW, fast_lim = PERIOD_FAST.
  - Synchronizer flops = 1 (released), debounce counter = 0.
- Reset mid-operation restores all limits to their parameter values. Written limits are lost.

## Timing
- Half-period is lim+1 cycles; full blink period is 2·(lim+1).
- ch_en rising at cycle 0: the first toggle (led goes to LED_ON) and the first wrap occur at cycle lim+1.
- cfg write: 1-cycle latency; the new limit is used in the compare on the cycle after cfg_we.
- resync: led and cnt update on the next clock edge; the next toggle follows lim+1 cycles later.
- Key: fast_o changes 2 + DB_CYC cycles after key_n settles; fast mode is applied to lim on that same edge.
- wrap is high for exactly one cycle per toggle. With lim=0 it is continuously high.

## Configuration
- KEY_DEBOUNCE_EN defined: the debouncer is compiled in. `fast` changes only after the synchronized key differs from `fast` for DB_CYC consecutive cycles; any bounce restarts the count.
- KEY_DEBOUNCE_EN undefined: the debouncer is omitted. `fast` is the inverted 2-FF synchronizer output, so latency is 2 cycles and DB_CYC is unused.

## Structure
- Package led_blink_pkg holds the LED_ON/LED_OFF constants, the default CLK_HZ of 27_000_000, and the helper that derives default period constants from milliseconds.
- Sub-module key_debounce contains the synchronizer plus debouncer. Its macro guard lives inside that sub-module.
- The channel logic is a generate loop in led_blink_gen; no further sub-modules.

## Test plan
Bench parameters: CH=3, PERIOD_SLOW=9, PERIOD_FAST=3, DB_CYC=4, KEY_DEBOUNCE_EN defined.
- Basic blink: release rst, key released, ch_en=3'b011 → led[0] and led[1] toggle every 10 cycles, first rise 10 cycles after enable; wrap pulses on each toggle; led[2] stays 0.
- Debounce: key_n low for 3 cycles and then high → fast_o stays 0. key_n low for 8 cycles → fast_o rises 6 cycles after the fall, and the half-period becomes 4 cycles.
- Limit lowered mid-count: cfg_we, cfg_ch=0, cfg_sel=0, cfg_data=5 while cnt[0]=7 → led[0] toggles on the next cycle, then every 6 cycles. A write with cfg_ch=3 changes nothing.
- Resync: pulse resync with channels out of phase → all enabled LEDs are 1 on the next edge and toggle together 10 cycles later.
- Reset mid-operation: assert rst asynchronously mid-count after a limit write → led=0, wrap=0 immediately (not waiting for a clock edge); after release the written channel blinks with a half-period of 10 cycles again.
